// File: rtl/snap_intr_pkg.sv
// Shared definitions for the SNAP interrupt arbiter: FSM encodings, default
// object width and the round-robin search used by every bridge arbiter.
package snap_intr_pkg;

  localparam int SRC_W_DEF = 64;
  localparam int MAX_SRC   = 16;

  localparam logic [4:0] ST_IDLE_ENC    = 5'b00001;
  localparam logic [4:0] ST_GRANT_ENC   = 5'b00010;
  localparam logic [4:0] ST_REQ_ENC     = 5'b00100;
  localparam logic [4:0] ST_RELEASE_ENC = 5'b01000;
  localparam logic [4:0] ST_DONE_ENC    = 5'b10000;

  typedef enum logic [4:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_GRANT   = ST_GRANT_ENC,
    ST_REQ     = ST_REQ_ENC,
    ST_RELEASE = ST_RELEASE_ENC,
    ST_DONE    = ST_DONE_ENC
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of pending at or after ptr, wrapping at num; ptr must be < num.
  function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0] pending,
                                       input logic [3:0]         ptr,
                                       input int                 num);
    rr_pick_t   res;
    logic [4:0] j;
    res = '0;
    for (int k = 0; k < MAX_SRC; k++) begin
      j = {1'b0, ptr} + 5'(k);
      if (j >= 5'(num)) j = j - 5'(num);
      if ((k < num) && !res.valid && pending[j[3:0]]) begin
        res.valid = 1'b1;
        res.idx   = j[3:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/snap_rr_arbiter.sv
// Combinational round-robin picker: searches req upward from ptr with wrap and
// returns the winner both one-hot and as an index.
module snap_rr_arbiter
  import snap_intr_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  rr_pick_t pick;

  always_comb begin
    pick      = rr_pick(16'(req), 4'(ptr), N);
    gnt_valid = pick.valid;
    gnt_idx   = IDX_W'(pick.idx);
    gnt       = pick.valid ? (N'(1) << pick.idx) : '0;
  end

endmodule

// File: rtl/snap_interrupt_arbiter.sv
// Collects edge-triggered interrupt requests from action/engine sources and
// serialises them, round-robin, onto the TLX bridge's level handshake.
module snap_interrupt_arbiter
  import snap_intr_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = SRC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       src_mask,
  input  logic [NUM_SRC-1:0]       irq_req,
  input  logic [NUM_SRC*SRC_W-1:0] irq_src,
  output logic [NUM_SRC-1:0]       irq_ack,
  output logic                     interrupt,
  output logic [SRC_W-1:0]         interrupt_src,
  input  logic                     interrupt_ack,
  output logic [NUM_SRC-1:0]       pending_vec,
  output logic [31:0]              int_count
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

  state_t             state;
  logic [NUM_SRC-1:0] irq_req_d;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [SRC_W-1:0]   gnt_obj;
  logic [SRC_W-1:0]   obj [NUM_SRC];

  snap_rr_arbiter #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (pending),
    .ptr       (rr_ptr),
    .gnt       (pick_gnt),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  // A fresh rise in the grant cycle re-sets its bit, so set wins over clear.
  always_comb begin
    rise = irq_req & ~irq_req_d & src_mask;
    clr  = (state == ST_GRANT) ? pick_gnt : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_req_d <= '0;
      pending   <= '0;
    end else begin
      irq_req_d <= irq_req;
      pending   <= (pending & ~clr) | rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) obj[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (rise[i]) obj[i] <= irq_src[i*SRC_W +: SRC_W];
      end
    end
  end

  // The in-flight object lives in gnt_obj so later rises on the same source
  // only touch obj[] and cannot disturb interrupt_src mid-delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      gnt_obj   <= '0;
      interrupt <= 1'b0;
      irq_ack   <= '0;
      int_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          irq_ack <= '0;
          if (pick_valid && !interrupt_ack) state <= ST_GRANT;
        end
        ST_GRANT: begin
          gnt_idx   <= pick_idx;
          gnt_obj   <= obj[pick_idx];
          rr_ptr    <= (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
          interrupt <= 1'b1;
          state     <= ST_REQ;
        end
        ST_REQ: begin
          if (interrupt_ack) begin
            interrupt <= 1'b0;
            state     <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!interrupt_ack) begin
            irq_ack   <= NUM_SRC'(1) << gnt_idx;
            int_count <= int_count + 32'd1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          irq_ack <= '0;
          state   <= ST_IDLE;
        end
        default: begin
          interrupt <= 1'b0;
          irq_ack   <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign interrupt_src = gnt_obj;
  assign pending_vec   = pending;

endmodule

// File: tb/tb_snap_interrupt_arbiter.sv
// Directed bench for snap_interrupt_arbiter: single/simultaneous requests,
// round-robin fairness, masking, re-request in flight and mid-delivery reset.
module tb_snap_interrupt_arbiter;

  localparam int NS = 4;
  localparam int SW = 64;

  logic             clk;
  logic             rst_n;
  logic [NS-1:0]    src_mask;
  logic [NS-1:0]    irq_req;
  logic [NS*SW-1:0] irq_src;
  logic [NS-1:0]    irq_ack;
  logic             interrupt;
  logic [SW-1:0]    interrupt_src;
  logic             interrupt_ack;
  logic [NS-1:0]    pending_vec;
  logic [31:0]      int_count;

  int total = 0;
  int bad   = 0;

  snap_interrupt_arbiter #(.NUM_SRC(NS), .SRC_W(SW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_mask      (src_mask),
    .irq_req       (irq_req),
    .irq_src       (irq_src),
    .irq_ack       (irq_ack),
    .interrupt     (interrupt),
    .interrupt_src (interrupt_src),
    .interrupt_ack (interrupt_ack),
    .pending_vec   (pending_vec),
    .int_count     (int_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NS-1:0] req);
    irq_req = req;
  endtask

  task automatic setObj(input int idx, input logic [SW-1:0] val);
    irq_src[idx*SW +: SW] = val;
  endtask

  task automatic applyReset();
    rst_n         = 1'b0;
    irq_req       = '0;
    interrupt_ack = 1'b0;
    src_mask      = '1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Bridge model: ack 5 cycles after interrupt, drop it 1 cycle after interrupt
  // falls; optionally re-pulse some requests while the delivery is in REQ.
  task automatic deliverOne(input string tag, input logic [SW-1:0] exp_obj,
                            input logic [NS-1:0] exp_ack, input logic [NS-1:0] exp_pend,
                            input logic [NS-1:0] rerise);
    logic          seen;
    int            pulses;
    logic [NS-1:0] ack_val;
    seen = interrupt;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = interrupt;
    end
    checkOutput({tag, "_irq"}, 64'(seen), 64'd1);
    if (!seen) return;
    checkOutput({tag, "_src"}, interrupt_src, exp_obj);
    checkOutput({tag, "_pend"}, 64'(pending_vec), 64'(exp_pend));
    if (rerise != '0) begin
      irq_req = irq_req & ~rerise;
      @(negedge clk);
      irq_req = irq_req | rerise;
      repeat (4) @(negedge clk);
    end else begin
      repeat (5) @(negedge clk);
    end
    checkOutput({tag, "_hold"}, interrupt_src, exp_obj);
    checkOutput({tag, "_lvl"}, 64'(interrupt), 64'd1);
    interrupt_ack = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = !interrupt;
    end
    checkOutput({tag, "_rel"}, 64'(seen), 64'd1);
    @(negedge clk);
    interrupt_ack = 1'b0;
    pulses  = 0;
    ack_val = '0;
    repeat (3) begin
      @(negedge clk);
      if (irq_ack != '0) begin
        pulses++;
        ack_val = irq_ack;
      end
    end
    checkOutput({tag, "_ackw"}, 64'(pulses), 64'd1);
    checkOutput({tag, "_ackv"}, 64'(ack_val), 64'(exp_ack));
  endtask

  initial begin
    logic any_int, any_ack, any_pend, seen;

    rst_n         = 1'b0;
    irq_req       = '0;
    src_mask      = '1;
    irq_src       = '0;
    interrupt_ack = 1'b0;
    #12;
    checkOutput("rst_int", 64'(interrupt), 64'd0);
    checkOutput("rst_ack", 64'(irq_ack), 64'd0);
    checkOutput("rst_pend", 64'(pending_vec), 64'd0);
    checkOutput("rst_cnt", 64'(int_count), 64'd0);
    checkOutput("rst_src", interrupt_src, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request and 3-clock latency
    applyReset();
    setObj(0, 64'h0000_0000_DEAD_BEEF);
    applyStimulus(4'b0001);
    @(negedge clk);
    checkOutput("t1_cap", 64'(pending_vec), 64'h1);
    checkOutput("t1_lat1", 64'(interrupt), 64'd0);
    @(negedge clk);
    checkOutput("t1_lat2", 64'(interrupt), 64'd0);
    @(negedge clk);
    checkOutput("t1_lat3", 64'(interrupt), 64'd1);
    deliverOne("t1", 64'hDEAD_BEEF, 4'b0001, 4'b0000, 4'b0000);
    checkOutput("t1_cnt", 64'(int_count), 64'd1);
    applyStimulus(4'b0000);

    // Simultaneous requests
    applyReset();
    setObj(0, 64'h10);
    setObj(1, 64'h11);
    setObj(3, 64'h13);
    applyStimulus(4'b1011);
    @(negedge clk);
    checkOutput("t2_cap", 64'(pending_vec), 64'hB);
    deliverOne("t2a", 64'h10, 4'b0001, 4'b1010, 4'b0000);
    deliverOne("t2b", 64'h11, 4'b0010, 4'b1000, 4'b0000);
    deliverOne("t2c", 64'h13, 4'b1000, 4'b0000, 4'b0000);
    checkOutput("t2_cnt", 64'(int_count), 64'd3);

    // Fairness: source 0 keeps re-requesting, source 2 must get its turn
    applyReset();
    setObj(0, 64'h20);
    setObj(2, 64'h22);
    applyStimulus(4'b0101);
    deliverOne("t3a", 64'h20, 4'b0001, 4'b0100, 4'b0001);
    deliverOne("t3b", 64'h22, 4'b0100, 4'b0001, 4'b0001);
    deliverOne("t3c", 64'h20, 4'b0001, 4'b0000, 4'b0000);
    checkOutput("t3_cnt", 64'(int_count), 64'd3);
    checkOutput("t3_pend", 64'(pending_vec), 64'd0);

    // Mask
    applyReset();
    src_mask = 4'b1110;
    setObj(0, 64'h30);
    applyStimulus(4'b0001);
    any_int  = 1'b0;
    any_ack  = 1'b0;
    any_pend = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any_int  = any_int | interrupt;
      any_ack  = any_ack | (|irq_ack);
      any_pend = any_pend | (|pending_vec);
    end
    checkOutput("t4_int", 64'(any_int), 64'd0);
    checkOutput("t4_ack", 64'(any_ack), 64'd0);
    checkOutput("t4_pend", 64'(any_pend), 64'd0);
    src_mask = 4'b1111;
    applyStimulus(4'b0000);
    @(negedge clk);
    applyStimulus(4'b0001);
    deliverOne("t4", 64'h30, 4'b0001, 4'b0000, 4'b0000);
    checkOutput("t4_cnt", 64'(int_count), 64'd1);

    // Re-request during flight: 0xA stays on the bus, 0xB follows
    applyReset();
    setObj(1, 64'hA);
    applyStimulus(4'b0010);
    @(negedge clk);
    setObj(1, 64'hB);
    deliverOne("t5a", 64'hA, 4'b0010, 4'b0000, 4'b0010);
    deliverOne("t5b", 64'hB, 4'b0010, 4'b0000, 4'b0000);
    checkOutput("t5_cnt", 64'(int_count), 64'd2);

    // Asynchronous reset while a delivery is in REQ with two pending
    applyReset();
    setObj(0, 64'h40);
    setObj(1, 64'h41);
    setObj(2, 64'h42);
    setObj(3, 64'h43);
    applyStimulus(4'b1111);
    deliverOne("t6a", 64'h40, 4'b0001, 4'b1110, 4'b0000);
    seen = interrupt;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = interrupt;
    end
    checkOutput("t6_irq", 64'(seen), 64'd1);
    checkOutput("t6_pend", 64'(pending_vec), 64'hC);
    #2;
    rst_n   = 1'b0;
    irq_req = '0;
    #1;
    checkOutput("t6_rint", 64'(interrupt), 64'd0);
    checkOutput("t6_rpend", 64'(pending_vec), 64'd0);
    checkOutput("t6_rack", 64'(irq_ack), 64'd0);
    checkOutput("t6_rcnt", 64'(int_count), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    any_int = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_int = any_int | interrupt | (|pending_vec);
    end
    checkOutput("t6_quiet", 64'(any_int), 64'd0);
    applyStimulus(4'b1000);
    deliverOne("t6b", 64'h43, 4'b1000, 4'b0000, 4'b0000);
    checkOutput("t6_cnt", 64'(int_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
